snn_image_loader: RTL

SNN_IMAGE_LOADER -- requirements
Module: snn_image_loader

---
 rtl/snn_pkg.sv | 22 ++
 rtl/loader_timeout.sv | 46 ++++
 rtl/snn_image_loader.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// -----------------------------------------------------------------------------
// snn_pkg
//   Shared definitions for the SNN image-loading path.
//   - loader_state_t : states of the UART-to-input-RAM loader
//   - IMG_BITS_DEF   : default number of image bits per frame (28 x 28)
//   - BYTES_PER_IMG  : bytes needed to carry one default frame
//   - ADDR_W         : input-RAM address width
// -----------------------------------------------------------------------------
package snn_pkg;

    localparam int IMG_BITS_DEF  = 784;
    localparam int BYTES_PER_IMG = 98;
    localparam int ADDR_W        = 10;

    typedef enum logic [1:0] {
        LOAD      = 2'd0,
        WRITE     = 2'd1,
        START     = 2'd2,
        WAIT_CORE = 2'd3
    } loader_state_t;

endpackage : snn_pkg

// File: rtl/loader_timeout.sv
// -----------------------------------------------------------------------------
// loader_timeout
//   Inter-byte idle watchdog for snn_image_loader. Only compiled when the
//   macro LOADER_TIMEOUT_EN is defined; without it no counter exists at all.
//
//   Parameters
//     TIMEOUT_CYCLES : idle cycles tolerated before expire fires
//   Ports
//     clk    in  system clock
//     rst_n  in  asynchronous active-low reset
//     enable in  high while a partial frame is waiting for its next byte
//     clear  in  a byte arrived this cycle; restart the idle count
//     expire out combinational, high during the TIMEOUT_CYCLES-th idle cycle
// -----------------------------------------------------------------------------
`ifdef LOADER_TIMEOUT_EN
module loader_timeout #(
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_IDLE = CNT_W'(TIMEOUT_CYCLES - 1);

    // count holds the number of idle cycles already completed, so the
    // cycle in which it equals TIMEOUT_CYCLES-1 is the last one allowed.
    logic [CNT_W-1:0] count;

    assign expire = enable && !clear && (count == LAST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!enable || clear || expire) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule : loader_timeout
`endif

// File: rtl/snn_image_loader.sv
// -----------------------------------------------------------------------------
// snn_image_loader
//   Receives image bytes from a UART, serialises each byte LSB-first into a
//   1-bit-wide input RAM, and launches the SNN core once a full frame of
//   IMG_BITS bits has been written. Bytes arriving while the loader cannot
//   accept them are dropped and flagged on the sticky overrun output.
//
//   Optional feature: define LOADER_TIMEOUT_EN to abandon a partial frame
//   after TIMEOUT_CYCLES idle cycles (frame_err pulses, bit pointer clears).
//   Without the macro frame_err is tied low and a partial frame waits forever.
//
//   Parameters
//     IMG_BITS       : image bits per frame (multiple of 8, at most 1024)
//     TIMEOUT_CYCLES : idle cycles allowed between bytes of one frame
//   Ports
//     clk        in   system clock
//     rst_n      in   asynchronous active-low reset
//     rx_rdy     in   one-cycle strobe, rx_data holds a received byte
//     rx_data    in   received byte
//     core_done  in   one-cycle strobe, SNN core finished classification
//     ram_we     out  input-RAM write enable (high only while writing bits)
//     ram_addr   out  input-RAM write address (always the bit pointer)
//     ram_d      out  input-RAM write data bit
//     start      out  one-cycle strobe launching the SNN core
//     busy       out  high from the start strobe until core_done
//     overrun    out  sticky, a byte was dropped; cleared by reset or start
//     frame_err  out  one-cycle strobe on inter-byte timeout
// -----------------------------------------------------------------------------
module snn_image_loader
    import snn_pkg::*;
#(
    parameter int IMG_BITS       = IMG_BITS_DEF,
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    input  logic              core_done,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_d,
    output logic              start,
    output logic              busy,
    output logic              overrun,
    output logic              frame_err
);

    // Frames must be whole bytes and fit the address space; the last-bit
    // test below relies on the final byte ending exactly at IMG_BITS-1.
    if ((IMG_BITS < 8) || (IMG_BITS % 8 != 0) || (IMG_BITS > (1 << ADDR_W))) begin : g_bad_img_bits
        $error("snn_image_loader: IMG_BITS must be a multiple of 8 in 8..1024");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("snn_image_loader: TIMEOUT_CYCLES must be at least 1");
    end

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_BITS - 1);

    loader_state_t     state;
    logic [7:0]        shift;
    logic [ADDR_W-1:0] bit_ptr;
    logic [2:0]        bit_cnt;
    logic              timeout_hit;

    // -------------------------------------------------------------------------
    // Optional inter-byte timeout
    // -------------------------------------------------------------------------
`ifdef LOADER_TIMEOUT_EN
    loader_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable ((state == LOAD) && (bit_ptr != '0)),
        .clear  (rx_rdy),
        .expire (timeout_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= timeout_hit;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign frame_err   = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Loader FSM
    // -------------------------------------------------------------------------
    // NOTE: every register here uses <= so all of them update from the same
    // pre-edge values; a blocking = would let later lines see new values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= LOAD;
            shift   <= '0;
            bit_ptr <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (rx_rdy) begin
                        shift   <= rx_data;
                        bit_cnt <= '0;
                        state   <= WRITE;
                    end else if (timeout_hit) begin
                        bit_ptr <= '0;
                    end
                end

                WRITE: begin
                    shift   <= {1'b0, shift[7:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) begin
                        // Final bit of the frame: hold the pointer at the last
                        // address so it never passes IMG_BITS-1; START clears it.
                        if (bit_ptr == LAST_ADDR) begin
                            state <= START;
                        end else begin
                            bit_ptr <= bit_ptr + 1'b1;
                            state   <= LOAD;
                        end
                    end else begin
                        bit_ptr <= bit_ptr + 1'b1;
                    end
                end

                START: begin
                    bit_ptr <= '0;
                    state   <= WAIT_CORE;
                end

                WAIT_CORE: begin
                    if (core_done) begin
                        state <= LOAD;
                    end
                end

                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

    // A byte dropped during the start cycle itself belongs to the new run,
    // so the set takes priority over the start-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (rx_rdy && (state != LOAD)) begin
            overrun <= 1'b1;
        end else if (state == START) begin
            overrun <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: pure decodes of registered state, so they go low as soon as
    // reset is asserted and never glitch on input changes.
    // -------------------------------------------------------------------------
    assign ram_we   = (state == WRITE);
    assign ram_addr = bit_ptr;
    assign ram_d    = shift[0];
    assign start    = (state == START);
    assign busy     = (state == START) || (state == WAIT_CORE);

endmodule : snn_image_loader
